// File: rtl/input_debouncer.sv
// Multi-channel switch/button conditioner: 2-flop synchroniser, per-channel debounce FSM, registered edge pulses.
// Optional DEBOUNCE_EVENT_CNT_EN adds evt_count, a saturating count of channel-0 rise pulses.
module input_debouncer #(
    parameter int NUM_CH          = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_WIDTH       = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] raw_in,
    output logic [NUM_CH-1:0] db_out,
    output logic [NUM_CH-1:0] rise_pulse,
    output logic [NUM_CH-1:0] fall_pulse
`ifdef DEBOUNCE_EVENT_CNT_EN
    ,
    output logic [7:0]        evt_count
`endif
);

    typedef enum logic [1:0] {LOW, WAIT_HIGH, HIGH, WAIT_LOW} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic [NUM_CH-1:0]    sync1_q, sync1_d;
    logic [NUM_CH-1:0]    s_q, s_d;
    logic [NUM_CH-1:0]    rise_q, rise_d;
    logic [NUM_CH-1:0]    fall_q, fall_d;
    state_t               state_q [NUM_CH];
    state_t               state_d [NUM_CH];
    logic [CNT_WIDTH-1:0] cnt_q   [NUM_CH];
    logic [CNT_WIDTH-1:0] cnt_d   [NUM_CH];

    // The first stable sample is the one that leaves LOW/HIGH, so the wait state starts at 1.
    always_comb begin
        sync1_d = raw_in;
        s_d     = sync1_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                LOW: begin
                    if (s_q[i]) begin
                        state_d[i] = WAIT_HIGH;
                        cnt_d[i]   = CNT_ONE;
                    end else begin
                        cnt_d[i] = '0;
                    end
                end
                WAIT_HIGH: begin
                    if (!s_q[i]) begin
                        state_d[i] = LOW;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = HIGH;
                        cnt_d[i]   = '0;
                        rise_d[i]  = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                HIGH: begin
                    if (!s_q[i]) begin
                        state_d[i] = WAIT_LOW;
                        cnt_d[i]   = CNT_ONE;
                    end else begin
                        cnt_d[i] = '0;
                    end
                end
                WAIT_LOW: begin
                    if (s_q[i]) begin
                        state_d[i] = HIGH;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = LOW;
                        cnt_d[i]   = '0;
                        fall_d[i]  = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[i] = LOW;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            s_q     <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= LOW;
                cnt_q[i]   <= '0;
            end
        end else begin
            sync1_q <= sync1_d;
            s_q     <= s_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The level is decoded from the state register so it moves on the same edge as the pulses.
    always_comb begin
        db_out = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            db_out[i] = (state_q[i] == HIGH) || (state_q[i] == WAIT_LOW);
        end
    end

    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

`ifdef DEBOUNCE_EVENT_CNT_EN
    logic [7:0] evt_q, evt_d;

    always_comb begin
        evt_d = evt_q;
        if (rise_d[0] && (evt_q != 8'hFF)) begin
            evt_d = evt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_q <= '0;
        end else begin
            evt_q <= evt_d;
        end
    end

    assign evt_count = evt_q;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench for input_debouncer (DEBOUNCE_CYCLES=4, NUM_CH=2): run-length reference model feeding an
// expected queue that is compared every cycle, plus directed latency/pulse-count checks per scenario.
module tb_input_debouncer;

    localparam int NUM_CH = 2;
    localparam int DC     = 4;
    localparam int CW     = 3;
    localparam int EW     = 3 * NUM_CH;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NUM_CH-1:0] raw_in = '0;
    logic [NUM_CH-1:0] db_out;
    logic [NUM_CH-1:0] rise_pulse;
    logic [NUM_CH-1:0] fall_pulse;
`ifdef DEBOUNCE_EVENT_CNT_EN
    logic [7:0]        evt_count;
`endif

    input_debouncer #(
        .NUM_CH(NUM_CH),
        .DEBOUNCE_CYCLES(DC),
        .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .raw_in(raw_in),
        .db_out(db_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse)
`ifdef DEBOUNCE_EVENT_CNT_EN
        ,
        .evt_count(evt_count)
`endif
    );

    // Clock / cycle counter
    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Checker
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: count consecutive synchronised samples that differ from the accepted level.
    logic [EW-1:0]     exp_q[$];
    logic [NUM_CH-1:0] m_sync1, m_s, m_db, m_rise, m_fall;
    int                run [NUM_CH];

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_sync1 = '0;
            m_s     = '0;
            m_db    = '0;
            m_rise  = '0;
            m_fall  = '0;
            for (int ch = 0; ch < NUM_CH; ch++) run[ch] = 0;
            exp_q.delete();
            exp_q.push_back({m_db, m_rise, m_fall});
        end else begin
            m_rise = '0;
            m_fall = '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (m_s[ch] != m_db[ch]) begin
                    run[ch]++;
                    if (run[ch] == DC) begin
                        m_db[ch] = m_s[ch];
                        if (m_s[ch]) m_rise[ch] = 1'b1;
                        else         m_fall[ch] = 1'b1;
                        run[ch] = 0;
                    end
                end else begin
                    run[ch] = 0;
                end
            end
            m_s     = m_sync1;
            m_sync1 = raw_in;
            exp_q.push_back({m_db, m_rise, m_fall});
        end
    end

    // Scoreboard: one expected entry per cycle, compared on the falling edge.
    int rise_cnt [NUM_CH];
    int fall_cnt [NUM_CH];
    bit mon_stop = 1'b0;

    initial begin
        logic [EW-1:0] e;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            rise_cnt[ch] = 0;
            fall_cnt[ch] = 0;
        end
        forever begin
            @(negedge clk);
            if (!mon_stop) begin
                if (exp_q.size() == 0) begin
                    check_eq("exp_q_underrun", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("db_out", 32'(db_out), 32'(e[EW-1 -: NUM_CH]));
                    check_eq("rise_pulse", 32'(rise_pulse), 32'(e[2*NUM_CH-1 -: NUM_CH]));
                    check_eq("fall_pulse", 32'(fall_pulse), 32'(e[NUM_CH-1:0]));
                end
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    rise_cnt[ch] += int'(rise_pulse[ch]);
                    fall_cnt[ch] += int'(fall_pulse[ch]);
                end
            end
        end
    end

    // Driver tasks
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_db(input int ch, input logic val, input string tag, output int at_cyc);
        bit seen;
        seen   = 1'b0;
        at_cyc = -1;
        for (int i = 0; i < 20 && !seen; i++) begin
            step(1);
            if (db_out[ch] === val) begin
                seen   = 1'b1;
                at_cyc = cyc;
            end
        end
        if (!seen) check_eq(tag, 32'(db_out[ch]), 32'(val));
    endtask

    initial begin
        int t0, at, r0, r1, f0, f1;

        // Reset state
        step(2);
        check_eq("reset_db", 32'(db_out), 0);
        check_eq("reset_rise", 32'(rise_pulse), 0);
        check_eq("reset_fall", 32'(fall_pulse), 0);
        rst = 1'b0;
        step(5);

        // Clean step on channel 0
        r0 = rise_cnt[0];
        r1 = rise_cnt[1];
        raw_in[0] = 1'b1;
        t0 = cyc;
        wait_db(0, 1'b1, "clean_wait", at);
        check_eq("clean_latency", at - t0, DC + 2);
        check_eq("clean_rise_now", 32'(rise_pulse[0]), 1);
        step(3);
        check_eq("clean_rise_count", rise_cnt[0] - r0, 1);
        check_eq("clean_ch1_rise", rise_cnt[1] - r1, 0);
        check_eq("clean_ch1_db", 32'(db_out[1]), 0);

        // Bounce rejection
        raw_in[0] = 1'b0;
        step(10);
        r0 = rise_cnt[0];
        f0 = fall_cnt[0];
        for (int k = 0; k < 4; k++) begin
            raw_in[0] = (k % 2 == 0);
            step(2);
        end
        raw_in[0] = 1'b0;
        step(10);
        check_eq("bounce_db", 32'(db_out[0]), 0);
        check_eq("bounce_rise", rise_cnt[0] - r0, 0);
        check_eq("bounce_fall", fall_cnt[0] - f0, 0);
        raw_in[0] = 1'b1;
        step(10);
        check_eq("bounce_hold_rise", rise_cnt[0] - r0, 1);
        check_eq("bounce_hold_db", 32'(db_out[0]), 1);

        // Falling edge on channel 1
        raw_in[1] = 1'b1;
        step(10);
        r1 = rise_cnt[1];
        f1 = fall_cnt[1];
        raw_in[1] = 1'b0;
        t0 = cyc;
        wait_db(1, 1'b0, "fall_wait", at);
        check_eq("fall_latency", at - t0, DC + 2);
        check_eq("fall_pulse_now", 32'(fall_pulse[1]), 1);
        step(3);
        check_eq("fall_count", fall_cnt[1] - f1, 1);
        check_eq("fall_no_rise", rise_cnt[1] - r1, 0);

        // Simultaneous rise on both channels
        raw_in = '0;
        step(10);
        raw_in = 2'b11;
        t0 = cyc;
        wait_db(0, 1'b1, "simul_wait", at);
        check_eq("simul_latency", at - t0, DC + 2);
        check_eq("simul_db", 32'(db_out), 32'h3);
        check_eq("simul_rise", 32'(rise_pulse), 32'h3);
        step(3);

        // Async reset while both levels are high, then restart with inputs held high
        rst = 1'b1;
        #1;
        check_eq("rst_async_db", 32'(db_out), 0);
        check_eq("rst_async_rise", 32'(rise_pulse), 0);
        step(2);
        rst = 1'b0;
        t0 = cyc;
        wait_db(0, 1'b1, "rst_hold_wait", at);
        check_eq("rst_hold_latency", at - t0, DC + 2);
        check_eq("rst_hold_db", 32'(db_out), 32'h3);

        // Async reset in WAIT_HIGH with cnt=2
        raw_in = '0;
        step(10);
        raw_in = 2'b01;
        t0 = cyc;
        step(4);
        rst = 1'b1;
        #1;
        check_eq("rst_mid_db", 32'(db_out), 0);
        check_eq("rst_mid_rise", 32'(rise_pulse), 0);
        step(2);
        rst = 1'b0;
        t0 = cyc;
        wait_db(0, 1'b1, "rst_mid_wait", at);
        check_eq("rst_mid_latency", at - t0, DC + 2);
        check_eq("rst_mid_ch1", 32'(db_out[1]), 0);

        // Constant input: no further events
        step(5);
        r0 = rise_cnt[0];
        f0 = fall_cnt[0];
        r1 = rise_cnt[1];
        f1 = fall_cnt[1];
        step(20);
        check_eq("idle_events", (rise_cnt[0] - r0) + (fall_cnt[0] - f0) + (rise_cnt[1] - r1) + (fall_cnt[1] - f1), 0);
        check_eq("idle_db", 32'(db_out), 32'h1);

`ifdef DEBOUNCE_EVENT_CNT_EN
        rst = 1'b1;
        #1;
        check_eq("evt_reset", 32'(evt_count), 0);
        step(2);
        rst = 1'b0;
        raw_in = '0;
        r0 = rise_cnt[0];
        for (int k = 0; k < 300; k++) begin
            raw_in[0] = 1'b1;
            step(7);
            raw_in[0] = 1'b0;
            step(7);
        end
        check_eq("evt_rises_seen", rise_cnt[0] - r0, 300);
        check_eq("evt_saturate", 32'(evt_count), ((rise_cnt[0] - r0) > 255) ? 255 : (rise_cnt[0] - r0));
        rst = 1'b1;
        #1;
        check_eq("evt_after_rst", 32'(evt_count), 0);
        step(2);
        rst = 1'b0;
        step(2);
`endif

        mon_stop = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
